lcd_text_frame_streamer: RTL
============================

// Module: lcd_text_frame_streamer
// PURPOSE
//  Two-row character frame buffer feeding the text-LCD driver.
//  User logic writes ASCII characters by (row, col). The block streams each row to the driver as a
//  {RS, DATA} byte sequence over a valid/ready handshake:
//    - line-1 DDRAM address command, then COLS characters;
//    - line-2 DDRAM address command, then COLS characters.
//  A new frame is emitted whenever the buffer is dirty.
// PARAMETERS
//  COLS        16     characters per row; column index width CW = $clog2(COLS)
//  LINE1_CMD   8'h80  set-DDRAM command for row 0 (RS=0)
//  LINE2_CMD   8'hC0  set-DDRAM command for row 1 (RS=0)
//  FILL_CHAR   8'h20  reset content of every buffer cell (space)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  wr_en        in   1   write wr_char into buffer[wr_row][wr_col] this cycle
//  wr_row       in   1   target row (0 = line 1, 1 = line 2)
//  wr_col       in   CW  target column
//  wr_char      in   8   ASCII code
//  refresh_req  in   1   force a frame without changing content
//  out_valid    out  1   byte presented to driver
//  out_ready    in   1   driver accepts byte; transfer = out_valid & out_ready
//  out_rs       out  1   0 = command byte, 1 = character byte
//  out_data     out  8   command or character
//  frame_busy   out  1   high whenever state != IDLE
//  frame_done   out  1   one-cycle pulse after the last byte of a frame transfers
// BEHAVIOUR
//  Reset (async, while rst=1):
//    - state=IDLE, all buffer cells=FILL_CHAR, dirty=1;
//    - out_valid=0, out_rs=0, out_data=8'h00, frame_busy=0, frame_done=0.
//  Buffer writes:
//    - Writes take effect at the clk edge and are independent of FSM state.
//    - A write with wr_col >= COLS is ignored and does not set dirty.
//  Dirty flag:
//    - Set by any accepted write or by refresh_req.
//    - Cleared on the edge that leaves IDLE.
//    - If set and clear occur on the same edge, set wins, so a second frame follows.
//  FSM: IDLE -> ADDR1 -> ROW1 -> ADDR2 -> ROW2 -> IDLE.
//    - IDLE: when dirty=1 at the edge, load {0, LINE1_CMD} and raise out_valid.
//    - ADDR1 / ADDR2: present one command byte.
//    - ROW1 / ROW2: present col = 0..COLS-1 of row 0 / row 1.
//    - Advance only on transfer. The next byte is loaded on the same edge, so valid stays high
//      back-to-back and gives 1 byte/cycle with out_ready held high.
//    - Transfer of the last ROW2 byte: out_valid drops, FSM returns to IDLE, frame_done pulses
//      in the following cycle.
//  Latency:
//    - wr_en high in cycle k (FSM in IDLE, dirty=0) -> dirty=1 after edge k -> out_valid=1 after
//      edge k+1.
//    - Frame = 2*COLS+2 transfers.
//    - Minimum IDLE dwell between frames: 1 cycle.
//  Data stability:
//    - out_rs and out_data are registers.
//    - While out_valid=1 and out_ready=0 they hold. A buffer write to the presented cell does not
//      alter the held byte; the new value goes out in the next frame via dirty.
//  Handshake:
//    - out_ready while out_valid=0 has no effect.
//    - out_valid never drops without a transfer, except on reset.
//  Reset mid-frame: outputs drop immediately; after release a complete fresh frame of FILL_CHAR
//  is emitted (dirty=1).
// TESTING
//  1. Release rst, out_ready=1 -> 34 transfers: 80h(RS0), 16x20h(RS1), C0h(RS0), 16x20h(RS1);
//     frame_done pulses once; FSM then idle.
//  2. Write "HELLO WORLD!" to row0 col0-11 and "20224401" to row1 col0-7 back-to-back
//     -> final frame carries 48h,45h,...,21h, 20h x4, then C0h, 32h,30h,...,31h, 20h x8.
//  3. out_ready pattern 1,0,0,1,0,1 during ROW1 -> out_data/out_rs stable while stalled;
//     no byte lost or duplicated (scoreboard compares the byte sequence).
//  4. Write row0 col0='Z' while FSM is in ROW2 -> current frame unchanged; next frame starts
//     after 1 IDLE cycle with byte 2 = 5Ah.
//  5. Assert rst after 10 transfers -> out_valid=0 with no clk edge; after release a full
//     FILL_CHAR frame is emitted.
//  6. wr_en and refresh_req together in IDLE -> exactly one frame; refresh_req alone -> frame
//     identical to the previous one.

Source files
------------

// File: rtl/lcd_text_frame_streamer_if.sv
// Byte stream from the frame streamer to the text-LCD driver: {RS, DATA} over valid/ready.
interface lcd_text_frame_streamer_if;
  logic       out_valid;
  logic       out_ready;
  logic       out_rs;
  logic [7:0] out_data;

  modport master (output out_valid, output out_rs, output out_data, input out_ready);
  modport slave  (input out_valid, input out_rs, input out_data, output out_ready);
endinterface

// File: rtl/lcd_text_frame_streamer.sv
// Two-row character frame buffer; streams line-address command plus COLS characters per row
// to the LCD driver whenever the buffer content has changed or a refresh is requested.
module lcd_text_frame_streamer #(
  parameter int          COLS      = 16,
  parameter logic [7:0]  LINE1_CMD = 8'h80,
  parameter logic [7:0]  LINE2_CMD = 8'hC0,
  parameter logic [7:0]  FILL_CHAR = 8'h20,
  localparam int         CW        = $clog2(COLS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          wr_row,
  input  logic [CW-1:0]                 wr_col,
  input  logic [7:0]                    wr_char,
  input  logic                          refresh_req,
  lcd_text_frame_streamer_if.master     drv,
  output logic                          frame_busy,
  output logic                          frame_done
);

  typedef enum logic [2:0] {IDLE, ADDR1, ROW1, ADDR2, ROW2} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [2][COLS];
  logic [CW-1:0] col, col_n, col_inc;
  logic          dirty, dirty_clr, wr_ok, xfer, last_col;
  logic          valid_q, valid_n, rs_q, rs_n, done_n;
  logic [7:0]    data_q, data_n;

  assign wr_ok    = wr_en && (32'(wr_col) < 32'(COLS));
  assign xfer     = valid_q & drv.out_ready;
  assign col_inc  = col + CW'(1);
  assign last_col = (col == CW'(COLS - 1));

  assign drv.out_valid = valid_q;
  assign drv.out_rs    = rs_q;
  assign drv.out_data  = data_q;
  assign frame_busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < 2; r++)
        for (int unsigned c = 0; c < COLS; c++)
          mem[r][c] <= FILL_CHAR;
    end else if (wr_ok) begin
      mem[wr_row][wr_col] <= wr_char;
    end
  end

  // Set has priority over clear so a write landing on the IDLE-exit edge still yields a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       dirty <= 1'b1;
    else if (wr_ok || refresh_req) dirty <= 1'b1;
    else if (dirty_clr)            dirty <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      valid_q    <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      valid_q    <= valid_n;
      rs_q       <= rs_n;
      data_q     <= data_n;
      frame_done <= done_n;
    end
  end

  // The next byte is fetched on the accepting edge, so the held byte never tracks buffer writes.
  always_comb begin
    state_n   = state;
    col_n     = col;
    valid_n   = valid_q;
    rs_n      = rs_q;
    data_n    = data_q;
    done_n    = 1'b0;
    dirty_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (dirty) begin
          state_n   = ADDR1;
          valid_n   = 1'b1;
          rs_n      = 1'b0;
          data_n    = LINE1_CMD;
          dirty_clr = 1'b1;
        end
      end
      ADDR1: begin
        if (xfer) begin
          state_n = ROW1;
          col_n   = '0;
          rs_n    = 1'b1;
          data_n  = mem[0][0];
        end
      end
      ROW1: begin
        if (xfer) begin
          if (last_col) begin
            state_n = ADDR2;
            rs_n    = 1'b0;
            data_n  = LINE2_CMD;
          end else begin
            col_n  = col_inc;
            data_n = mem[0][col_inc];
          end
        end
      end
      ADDR2: begin
        if (xfer) begin
          state_n = ROW2;
          col_n   = '0;
          rs_n    = 1'b1;
          data_n  = mem[1][0];
        end
      end
      ROW2: begin
        if (xfer) begin
          if (last_col) begin
            state_n = IDLE;
            valid_n = 1'b0;
            rs_n    = 1'b0;
            data_n  = '0;
            done_n  = 1'b1;
          end else begin
            col_n  = col_inc;
            data_n = mem[1][col_inc];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
